// File: rtl/fcmp_pkg.sv
// ---------------------------------------------------------------------------
// fcmp_pkg
//
// Shared definitions for the FloPoCo-format float compare/reduce blocks.
// A FloPoCo word of width W = WE + WF + 3 is laid out as:
//   [W-1:W-2]  exception field (zero / normal / inf / NaN)
//   [W-3]      sign
//   [W-4:WF]   biased exponent
//   [WF-1:0]   fraction
//
// Contents:
//   DEFAULT_WE / DEFAULT_WF / DEFAULT_W : default format widths
//   EXC_ZERO / EXC_NORMAL / EXC_INF / EXC_NAN : exception field encodings
//   state_t : control states of the max/argmax reducer
//   exc_is_nan : helper that flags an unordered exception field
// ---------------------------------------------------------------------------
package fcmp_pkg;

    localparam int DEFAULT_WE = 3;
    localparam int DEFAULT_WF = 3;
    localparam int DEFAULT_W  = DEFAULT_WE + DEFAULT_WF + 3;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic exc_is_nan(input logic [1:0] exc);
        return (exc == EXC_NAN);
    endfunction

endpackage

// File: rtl/fcmp_max_reduce_fcmplt.sv
// ---------------------------------------------------------------------------
// fcmplt
//
// Purely combinational "less than" comparator for FloPoCo-format floats.
//
// Ports:
//   X, Y       in   W   operands (W = WE + WF + 3)
//   unordered  out  1   at least one operand is NaN
//   XltY       out  1   X < Y; forced low whenever the pair is unordered
//
// Ordering: -inf < negative normals < (-0 == +0) < positive normals < +inf.
// Zeros carry no sign for ordering purposes, so +0 and -0 compare equal.
// ---------------------------------------------------------------------------
module fcmplt
    import fcmp_pkg::*;
#(
    parameter int WE = DEFAULT_WE,
    parameter int WF = DEFAULT_WF
) (
    input  logic [WE+WF+2:0] X,
    input  logic [WE+WF+2:0] Y,
    output logic             unordered,
    output logic             XltY
);

    localparam int W  = WE + WF + 3;
    localparam int EF = WE + WF;

    logic [1:0]    x_exc;
    logic [1:0]    y_exc;
    logic          x_sgn;
    logic          y_sgn;
    logic [EF-1:0] x_ef;
    logic [EF-1:0] y_ef;
    logic          x_neg;
    logic          y_neg;
    logic [EF+1:0] x_key;
    logic [EF+1:0] y_key;

    // Split both operands into fields and build a magnitude key.
    // The exception code sits on top of the key so that zero < any normal
    // < inf falls out of a plain unsigned compare; exponent/fraction bits
    // only matter for normals and are masked off for zero and inf.
    // A value counts as negative only when it is non-zero, which is what
    // makes -0 and +0 land on the same side and compare equal.
    always_comb begin
        x_exc = X[W-1:W-2];
        y_exc = Y[W-1:W-2];
        x_sgn = X[W-3];
        y_sgn = Y[W-3];
        x_ef  = X[EF-1:0];
        y_ef  = Y[EF-1:0];

        x_key = {x_exc, x_ef & {EF{x_exc == EXC_NORMAL}}};
        y_key = {y_exc, y_ef & {EF{y_exc == EXC_NORMAL}}};

        x_neg = x_sgn & (x_exc != EXC_ZERO);
        y_neg = y_sgn & (y_exc != EXC_ZERO);
    end

    // Decide the ordering. Mixed signs resolve on sign alone; equal signs
    // compare magnitude keys, reversing the sense for negative values.
    always_comb begin
        unordered = exc_is_nan(x_exc) | exc_is_nan(y_exc);
        XltY      = 1'b0;
        if (!unordered) begin
            case ({x_neg, y_neg})
                2'b10:   XltY = 1'b1;
                2'b01:   XltY = 1'b0;
                2'b00:   XltY = (x_key < y_key);
                2'b11:   XltY = (x_key > y_key);
                default: XltY = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fcmp_max_reduce.sv
// ---------------------------------------------------------------------------
// fcmp_max_reduce
//
// Sequential max / argmax reducer for FloPoCo-format floats. One element is
// consumed per cycle over a valid/ready handshake; a single shared fcmplt
// instance compares the running maximum against the incoming element.
// After N elements the maximum, its index and a sticky NaN flag are
// presented and held until the consumer takes them.
//
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      begin a reduction (only honoured in IDLE)
//   in_valid   in   1      element valid
//   in_ready   out  1      element accepted when in_valid & in_ready
//   in_data    in   W      element word
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      result consumed
//   out_max    out  W      maximum element
//   out_idx    out  IDX_W  index of the maximum element
//   out_nan    out  1      at least one element was NaN
//   busy       out  1      high while accumulating or holding a result
// ---------------------------------------------------------------------------
module fcmp_max_reduce
    import fcmp_pkg::*;
#(
    parameter int WE    = DEFAULT_WE,
    parameter int WF    = DEFAULT_WF,
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WE+WF+2:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WE+WF+2:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_nan,
    output logic             busy
);

    localparam int W     = WE + WF + 3;
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic cmp_unordered;
    logic cmp_lt;
    logic max_is_nan;
    logic in_is_nan;
    logic replace_max;

    // The one shared comparator: the running maximum is always X and the
    // element currently on the input bus is always Y.
    fcmplt #(
        .WE (WE),
        .WF (WF)
    ) u_cmp (
        .X         (out_max),
        .Y         (in_data),
        .unordered (cmp_unordered),
        .XltY      (cmp_lt)
    );

    // Replacement decision for elements after the first. A strictly larger
    // element wins, so ties leave the earlier index in place. NaN never
    // replaces anything, except that a NaN sitting in the max register
    // (which can only have come from element 0) is displaced by the first
    // ordered element that follows it. cmp_lt is already low for any
    // unordered pair, so the two terms never overlap.
    always_comb begin
        max_is_nan  = exc_is_nan(out_max[W-1:W-2]);
        in_is_nan   = exc_is_nan(in_data[W-1:W-2]);
        replace_max = cmp_lt | (max_is_nan & ~in_is_nan);
    end

    // Control FSM, element counter and result registers in one place.
    // Handshake outputs are registered alongside the state so that in_ready,
    // out_valid and busy always change on the same edge as the state.
    // In ACC an element is accepted whenever in_valid is high; with
    // in_valid low nothing moves. The last accept (cnt == N-1) moves to DONE
    // on the same edge. Results are only written while accumulating, so they
    // stay frozen through DONE and the following IDLE until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_nan   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACC;
                        cnt      <= '0;
                        out_idx  <= '0;
                        out_nan  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                ACC: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;

                        if (cnt == '0) begin
                            out_max <= in_data;
                            out_idx <= '0;
                            if (in_is_nan) begin
                                out_nan <= 1'b1;
                            end
                        end else begin
                            if (replace_max) begin
                                out_max <= in_data;
                                out_idx <= cnt[IDX_W-1:0];
                            end
                            if (cmp_unordered) begin
                                out_nan <= 1'b1;
                            end
                        end

                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcmp_max_reduce.sv
// ---------------------------------------------------------------------------
// tb_fcmp_max_reduce
//
// Bench for fcmp_max_reduce. Drives directed element streams into an N=4
// instance and a single-element N=1 instance. Expected results come from a
// value-level model that converts each word to a real number and picks the
// earliest maximum among the ordered elements.
// ---------------------------------------------------------------------------
module tb_fcmp_max_reduce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_max;
    logic [1:0] out_idx;
    logic       out_nan;
    logic       busy;

    logic       start_s;
    logic       in_valid_s;
    logic       in_ready_s;
    logic [8:0] in_data_s;
    logic       out_valid_s;
    logic       out_ready_s;
    logic [8:0] out_max_s;
    logic [0:0] out_idx_s;
    logic       out_nan_s;
    logic       busy_s;

    fcmp_max_reduce #(.WE(3), .WF(3), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_nan   (out_nan),
        .busy      (busy)
    );

    fcmp_max_reduce #(.WE(3), .WF(3), .N(1)) dut_single (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_data   (in_data_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_max   (out_max_s),
        .out_idx   (out_idx_s),
        .out_nan   (out_nan_s),
        .busy      (busy_s)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_max;
    int         exp_idx;
    bit         exp_nan;
    bit         model_chk = 1'b0;
    logic [8:0] vec [4];

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Real value of a FloPoCo word (WE=3, bias 3, WF=3); inf maps to a huge
    // magnitude. NaN is handled by the caller.
    function automatic real fpValue(input logic [8:0] w);
        real mag;
        int  e;
        mag = 0.0;
        case (w[8:7])
            2'b00: mag = 0.0;
            2'b01: begin
                mag = 1.0 + real'(w[2:0]) / 8.0;
                e   = int'(w[5:3]) - 3;
                while (e > 0) begin mag = mag * 2.0; e--; end
                while (e < 0) begin mag = mag / 2.0; e++; end
            end
            default: mag = 1.0e30;
        endcase
        return w[6] ? -mag : mag;
    endfunction

    // Result of a reduction: the earliest element holding the largest value
    // among the non-NaN elements; if every element is NaN, element 0.
    function automatic void modelReduce(input logic [8:0] v [4], input int n,
                                        output logic [8:0] mx, output int idx, output bit nan);
        real best;
        bit  found;
        mx    = v[0];
        idx   = 0;
        nan   = 1'b0;
        found = 1'b0;
        best  = 0.0;
        for (int i = 0; i < n; i++) begin
            if (v[i][8:7] == 2'b11) begin
                nan = 1'b1;
            end else if (!found || fpValue(v[i]) > best) begin
                found = 1'b1;
                best  = fpValue(v[i]);
                mx    = v[i];
                idx   = i;
            end
        end
    endfunction

    // Whenever a result is presented, it must match the model.
    always @(negedge clk) begin
        if (model_chk && out_valid === 1'b1) begin
            checkOutput("done_max", 32'(out_max), 32'(exp_max));
            checkOutput("done_idx", 32'(out_idx), 32'(exp_idx));
            checkOutput("done_nan", 32'(out_nan), 32'(exp_nan));
        end
    end

    // Run one reduction of vec on the N=4 instance. With stall set, in_valid
    // follows 1,0,0,1,0,0,... so only every third cycle carries an element.
    // hold is the number of extra DONE cycles with out_ready low.
    task automatic applyStimulus(input bit stall, input int hold, input int exp_lat);
        int  k;
        int  cyc;
        int  t;
        bit  acc;
        modelReduce(vec, 4, exp_max, exp_idx, exp_nan);
        model_chk = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k   = 0;
        cyc = 1;
        t   = 0;
        while (k < 4 && cyc < 60) begin
            in_valid = (!stall || (t % 3 == 0)) ? 1'b1 : 1'b0;
            in_data  = vec[k];
            checkOutput("acc_in_ready", 32'(in_ready), 32'd1);
            checkOutput("acc_no_valid", 32'(out_valid), 32'd0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            t++;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("accept_count", 32'(k), 32'd4);
        checkOutput("out_valid_rise", 32'(out_valid), 32'd1);
        checkOutput("latency", 32'(cyc), 32'(exp_lat));
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd1);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("held_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_chk = 1'b0;
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_max", 32'(out_max), 32'(exp_max));
        checkOutput("idle_idx", 32'(out_idx), 32'(exp_idx));
        checkOutput("idle_nan", 32'(out_nan), 32'(exp_nan));
    endtask

    logic [8:0] m_max;
    int         m_idx;
    bit         m_nan;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        start_s     = 1'b0;
        in_valid_s  = 1'b0;
        in_data_s   = '0;
        out_ready_s = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_max", 32'(out_max), 32'd0);
        checkOutput("rst_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_nan", 32'(out_nan), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_s_busy", 32'(busy_s), 32'd0);
        rst_n = 1'b1;

        // Pin the model with hand-computed results.
        vec = '{9'h098, 9'h0A0, 9'h0D8, 9'h098};
        modelReduce(vec, 4, m_max, m_idx, m_nan);
        checkOutput("model_t1", {m_max, 8'(m_idx), 7'd0, m_nan}, {9'h0A0, 8'd1, 7'd0, 1'b0});
        vec = '{9'h140, 9'h0D8, 9'h040, 9'h000};
        modelReduce(vec, 4, m_max, m_idx, m_nan);
        checkOutput("model_t2", {m_max, 8'(m_idx), 7'd0, m_nan}, {9'h040, 8'd2, 7'd0, 1'b0});
        vec = '{9'h098, 9'h180, 9'h100, 9'h0A0};
        modelReduce(vec, 4, m_max, m_idx, m_nan);
        checkOutput("model_t3", {m_max, 8'(m_idx), 7'd0, m_nan}, {9'h100, 8'd2, 7'd0, 1'b1});
        vec = '{9'h180, 9'h098, 9'h0D8, 9'h0D8};
        modelReduce(vec, 4, m_max, m_idx, m_nan);
        checkOutput("model_t4", {m_max, 8'(m_idx), 7'd0, m_nan}, {9'h098, 8'd1, 7'd0, 1'b1});

        // Directed streams, no stalls: result appears 5 cycles after start.
        vec = '{9'h098, 9'h0A0, 9'h0D8, 9'h098};
        applyStimulus(1'b0, 2, 5);
        vec = '{9'h140, 9'h0D8, 9'h040, 9'h000};
        applyStimulus(1'b0, 1, 5);
        vec = '{9'h098, 9'h180, 9'h100, 9'h0A0};
        applyStimulus(1'b0, 1, 5);
        vec = '{9'h180, 9'h098, 9'h0D8, 9'h0D8};
        applyStimulus(1'b0, 1, 5);

        // Backpressure: sparse in_valid and a 3-cycle hold in DONE.
        vec = '{9'h0D8, 9'h000, 9'h0A0, 9'h100};
        applyStimulus(1'b1, 3, 11);

        // Reset in the middle of accumulation discards everything.
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 9'h0A0;
        @(posedge clk); #1;
        in_data  = 9'h180;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("mid_rst_max", 32'(out_max), 32'd0);
        checkOutput("mid_rst_idx", 32'(out_idx), 32'd0);
        checkOutput("mid_rst_nan", 32'(out_nan), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        vec = '{9'h098, 9'h0A0, 9'h0D8, 9'h098};
        applyStimulus(1'b0, 1, 5);

        // Single-element instance; start during DONE must be ignored.
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        checkOutput("n1_in_ready", 32'(in_ready_s), 32'd1);
        in_valid_s = 1'b1;
        in_data_s  = 9'h140;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        checkOutput("n1_valid", 32'(out_valid_s), 32'd1);
        checkOutput("n1_max", 32'(out_max_s), 32'h140);
        checkOutput("n1_idx", 32'(out_idx_s), 32'd0);
        checkOutput("n1_nan", 32'(out_nan_s), 32'd0);
        start_s     = 1'b1;
        out_ready_s = 1'b0;
        @(posedge clk); #1;
        checkOutput("n1_start_in_done_valid", 32'(out_valid_s), 32'd1);
        checkOutput("n1_start_in_done_ready", 32'(in_ready_s), 32'd0);
        out_ready_s = 1'b1;
        @(posedge clk); #1;
        start_s     = 1'b0;
        out_ready_s = 1'b0;
        checkOutput("n1_release_valid", 32'(out_valid_s), 32'd0);
        checkOutput("n1_release_busy", 32'(busy_s), 32'd0);
        @(posedge clk); #1;
        checkOutput("n1_stays_idle", 32'(busy_s), 32'd0);
        checkOutput("n1_idle_max", 32'(out_max_s), 32'h140);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
